// File: rtl/osd_ctm_mc_pkg.sv
// Shared constants and record-layout helpers for the multi-channel core trace front-end.
// Record layout, MSB to LSB: ovf(1) type(5) prv(2) pc(AW) npc(AW) ts(TW).
package osd_ctm_mc_pkg;

  localparam int EV_JAL  = 0;
  localparam int EV_JALR = 1;
  localparam int EV_BR   = 2;
  localparam int EV_TRAP = 3;
  localparam int EV_PRV  = 4;

  function automatic int rec_width(int aw, int tw);
    return 8 + 2 * aw + tw;
  endfunction

  function automatic int npc_lsb(int tw);
    return tw;
  endfunction

  function automatic int pc_lsb(int aw, int tw);
    return tw + aw;
  endfunction

  function automatic int prv_lsb(int aw, int tw);
    return tw + 2 * aw;
  endfunction

  function automatic int type_lsb(int aw, int tw);
    return tw + 2 * aw + 2;
  endfunction

  function automatic int ovf_bit(int aw, int tw);
    return tw + 2 * aw + 7;
  endfunction

endpackage

// File: rtl/osd_ctm_mc_if.sv
// Retire-side inputs, capture controls and the output record stream of osd_ctm_mc.
interface osd_ctm_mc_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int NUM_CH     = 2,
  parameter int TS_WIDTH   = 32
);
  import osd_ctm_mc_pkg::*;

  localparam int EW = rec_width(ADDR_WIDTH, TS_WIDTH);

  logic                         cfg_enable;
  logic [4:0]                   cfg_event_mask;
  logic                         stall;
  logic [NUM_CH-1:0]            trace_valid;
  logic [NUM_CH*ADDR_WIDTH-1:0] trace_pc;
  logic [NUM_CH*ADDR_WIDTH-1:0] trace_npc;
  logic [NUM_CH-1:0]            trace_jal;
  logic [NUM_CH-1:0]            trace_jalr;
  logic [NUM_CH-1:0]            trace_branch;
  logic [NUM_CH-1:0]            trace_br_taken;
  logic [NUM_CH-1:0]            trace_trap;
  logic [NUM_CH-1:0]            trace_xcpt;
  logic [1:0]                   trace_prv;

  // Record stream: a record transfers on a rising edge with out_valid & out_ready;
  // once raised, out_valid and out_data hold until that transfer happens.
  logic [EW-1:0]                out_data;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output cfg_enable, cfg_event_mask, stall, trace_valid, trace_pc, trace_npc,
           trace_jal, trace_jalr, trace_branch, trace_br_taken, trace_trap,
           trace_xcpt, trace_prv, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  cfg_enable, cfg_event_mask, stall, trace_valid, trace_pc, trace_npc,
           trace_jal, trace_jalr, trace_branch, trace_br_taken, trace_trap,
           trace_xcpt, trace_prv, out_ready,
    output out_data, out_valid
  );

endinterface

// File: rtl/osd_fifo_mwr.sv
// FIFO accepting up to NWR in-order writes per cycle, with a free count and one
// valid/ready read port. The writer must never request more entries than free_o.
module osd_fifo_mwr #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int NWR   = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CW-1:0]      wr_cnt_i,
  input  logic [NWR*WIDTH-1:0] wr_data_i,
  output logic [CW-1:0]      free_o,
  output logic [WIDTH-1:0]   rd_data_o,
  output logic               rd_valid_o,
  input  logic               rd_ready_i
);

  localparam int AI = $clog2(DEPTH);
  localparam int PW = AI + 1;

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]    used;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AI-1:0]    waddr [NWR];
  logic             empty, full, pop;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[AI-1:0] == rd_ptr_q[AI-1:0]);
  assign used       = wr_ptr_q - rd_ptr_q;
  assign free_o     = full ? '0 : (CW'(DEPTH) - CW'(used));
  assign rd_valid_o = ~empty;
  assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q[AI-1:0]];
  assign pop        = rd_valid_o & rd_ready_i;

  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      waddr[j] = wr_ptr_q[AI-1:0] + AI'(j);
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < NWR; j++) begin
      if (CW'(j) < wr_cnt_i) begin
        mem_q[waddr[j]] <= wr_data_i[j*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(wr_cnt_i);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
    end
  end

endmodule

// File: rtl/osd_ctm_mc.sv
// Multi-channel core trace capture: filters retires and privilege changes, timestamps
// them and queues them in program order, reporting lost events with an overflow record.
module osd_ctm_mc
  import osd_ctm_mc_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int NUM_CH     = 2,
  parameter int TS_WIDTH   = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic         clk,
  input logic         rst_n,
  osd_ctm_mc_if.slave bus
);

  localparam int EW     = rec_width(ADDR_WIDTH, TS_WIDTH);
  localparam int NWR    = NUM_CH + 2;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int CNW    = CNT_WIDTH + 1;
  localparam int OVF_B  = ovf_bit(ADDR_WIDTH, TS_WIDTH);
  localparam int TYPE_L = type_lsb(ADDR_WIDTH, TS_WIDTH);
  localparam int PRV_L  = prv_lsb(ADDR_WIDTH, TS_WIDTH);
  localparam int PC_L   = pc_lsb(ADDR_WIDTH, TS_WIDTH);
  localparam int NPC_L  = npc_lsb(TS_WIDTH);
  localparam logic [4:0] PRV_TYPE = 5'(1 << EV_PRV);

  function automatic logic [EW-1:0] mk_rec(logic ovf, logic [4:0] typ, logic [1:0] prv,
                                           logic [ADDR_WIDTH-1:0] pc,
                                           logic [ADDR_WIDTH-1:0] npc,
                                           logic [TS_WIDTH-1:0] ts);
    logic [EW-1:0] r;
    r                      = '0;
    r[OVF_B]               = ovf;
    r[TYPE_L +: 5]         = typ;
    r[PRV_L +: 2]          = prv;
    r[PC_L +: ADDR_WIDTH]  = pc;
    r[NPC_L +: ADDR_WIDTH] = npc;
    r[0 +: TS_WIDTH]       = ts;
    return r;
  endfunction

  logic [1:0]           prv_q;
  logic [TS_WIDTH-1:0]  ts_q;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [CNT_WIDTH:0]   drop_sum;
  logic [4:0]           raw_type [NUM_CH];
  logic [NUM_CH-1:0]    qual;
  logic [EW-1:0]        lst [NWR];
  logic [CW-1:0]        free, needed, n_ev, wr_cnt;
  logic [NWR*EW-1:0]    wr_data;
  logic                 p_pend, prv_ev, capture;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      raw_type[i]          = '0;
      raw_type[i][EV_JAL]  = bus.trace_jal[i];
      raw_type[i][EV_JALR] = bus.trace_jalr[i];
      raw_type[i][EV_BR]   = bus.trace_branch[i] & bus.trace_br_taken[i];
      raw_type[i][EV_TRAP] = bus.trace_trap[i] | bus.trace_xcpt[i];
      qual[i] = bus.trace_valid[i] & (|(raw_type[i] & bus.cfg_event_mask));
    end
  end

  // Compact the write list: overflow record, privilege change, then channels oldest-first.
  always_comb begin
    int k;
    p_pend  = (drop_q != '0);
    prv_ev  = (prv_q != bus.trace_prv) & bus.cfg_event_mask[EV_PRV];
    capture = bus.cfg_enable & ~bus.stall;
    for (int j = 0; j < NWR; j++) begin
      lst[j] = '0;
    end
    k = 0;
    if (p_pend) begin
      lst[k] = mk_rec(1'b1, 5'b0, bus.trace_prv, ADDR_WIDTH'(drop_q), '0, ts_q);
      k = k + 1;
    end
    if (prv_ev) begin
      lst[k] = mk_rec(1'b0, PRV_TYPE, bus.trace_prv, '0, '0, ts_q);
      k = k + 1;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (qual[i]) begin
        lst[k] = mk_rec(1'b0, raw_type[i] & bus.cfg_event_mask, bus.trace_prv,
                        bus.trace_pc[i*ADDR_WIDTH +: ADDR_WIDTH],
                        bus.trace_npc[i*ADDR_WIDTH +: ADDR_WIDTH], ts_q);
        k = k + 1;
      end
    end
    needed = CW'(k);
    n_ev   = needed - CW'(p_pend);
    for (int j = 0; j < NWR; j++) begin
      wr_data[j*EW +: EW] = lst[j];
    end
  end

  // All-or-nothing admission; a pending overflow record alone may squeeze into one slot.
  always_comb begin
    wr_cnt   = '0;
    drop_d   = drop_q;
    drop_sum = {1'b0, drop_q} + CNW'(n_ev);
    if (capture) begin
      if (free >= needed) begin
        wr_cnt = needed;
        drop_d = '0;
      end else if (p_pend && (free != '0)) begin
        wr_cnt = CW'(1);
        drop_d = CNT_WIDTH'(n_ev);
      end else begin
        drop_d = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prv_q  <= 2'b11;
      ts_q   <= '0;
      drop_q <= '0;
    end else begin
      prv_q  <= bus.trace_prv;
      ts_q   <= ts_q + TS_WIDTH'(1);
      drop_q <= drop_d;
    end
  end

  osd_fifo_mwr #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .NWR   (NWR)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_cnt_i   (wr_cnt),
    .wr_data_i  (wr_data),
    .free_o     (free),
    .rd_data_o  (bus.out_data),
    .rd_valid_o (bus.out_valid),
    .rd_ready_i (bus.out_ready)
  );

endmodule

// File: tb/tb_osd_ctm_mc.sv
// Bench for osd_ctm_mc: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed record fields.
module tb_osd_ctm_mc;

  localparam int AW    = 64;
  localparam int NCH   = 2;
  localparam int TW    = 4;
  localparam int DEPTH = 8;
  localparam int CNTW  = 16;
  localparam int EW    = 8 + 2 * AW + TW;
  localparam int TY_L  = TW + 2 * AW + 2;
  localparam int PRV_L = TW + 2 * AW;
  localparam int PC_L  = TW + AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  int            m_ts, m_drop;
  logic [1:0]    m_prv;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  osd_ctm_mc_if #(.ADDR_WIDTH(AW), .NUM_CH(NCH), .TS_WIDTH(TW)) bus ();

  osd_ctm_mc #(
    .ADDR_WIDTH (AW),
    .NUM_CH     (NCH),
    .TS_WIDTH   (TW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CNTW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- helpers ----------------
  function automatic logic [EW-1:0] mk(logic ovf, logic [4:0] typ, logic [1:0] prv,
                                       logic [AW-1:0] pc, logic [AW-1:0] npc,
                                       logic [TW-1:0] ts);
    return {ovf, typ, prv, pc, npc, ts};
  endfunction

  function automatic logic [63:0] f_ovf(logic [EW-1:0] r); return 64'(r[EW-1]); endfunction
  function automatic logic [63:0] f_ty(logic [EW-1:0] r);  return 64'(r[TY_L +: 5]); endfunction
  function automatic logic [63:0] f_prv(logic [EW-1:0] r); return 64'(r[PRV_L +: 2]); endfunction
  function automatic logic [63:0] f_pc(logic [EW-1:0] r);  return r[PC_L +: AW]; endfunction
  function automatic logic [63:0] f_npc(logic [EW-1:0] r); return r[TW +: AW]; endfunction
  function automatic logic [63:0] f_ts(logic [EW-1:0] r);  return 64'(r[0 +: TW]); endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rec(string nm, logic [EW-1:0] act, logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    bus.trace_valid    = '0;
    bus.trace_jal      = '0;
    bus.trace_jalr     = '0;
    bus.trace_branch   = '0;
    bus.trace_br_taken = '0;
    bus.trace_trap     = '0;
    bus.trace_xcpt     = '0;
    bus.trace_pc       = '0;
    bus.trace_npc      = '0;
  endtask

  // a = {xcpt, trap, br_taken, branch, jalr, jal}
  task automatic set_ch(int ch, logic [5:0] a, logic [63:0] pc, logic [63:0] npc);
    bus.trace_valid[ch]         = 1'b1;
    bus.trace_jal[ch]           = a[0];
    bus.trace_jalr[ch]          = a[1];
    bus.trace_branch[ch]        = a[2];
    bus.trace_br_taken[ch]      = a[3];
    bus.trace_trap[ch]          = a[4];
    bus.trace_xcpt[ch]          = a[5];
    bus.trace_pc[ch*AW +: AW]   = pc;
    bus.trace_npc[ch*AW +: AW]  = npc;
  endtask

  // ---------------- reference model ----------------
  task automatic model_step();
    logic [EW-1:0] ev[$];
    logic [4:0]    raw;
    int            free, need;
    bit            pop, pend;
    free = DEPTH - exp_q.size();
    pop  = (exp_q.size() != 0) && bus.out_ready;
    if (m_prv != bus.trace_prv && bus.cfg_event_mask[4])
      ev.push_back(mk(1'b0, 5'b10000, bus.trace_prv, '0, '0, TW'(m_ts)));
    for (int i = 0; i < NCH; i++) begin
      raw = {1'b0, bus.trace_trap[i] | bus.trace_xcpt[i],
             bus.trace_branch[i] & bus.trace_br_taken[i],
             bus.trace_jalr[i], bus.trace_jal[i]};
      if (bus.trace_valid[i] && (raw & bus.cfg_event_mask) != 5'b0)
        ev.push_back(mk(1'b0, raw & bus.cfg_event_mask, bus.trace_prv,
                        bus.trace_pc[i*AW +: AW], bus.trace_npc[i*AW +: AW], TW'(m_ts)));
    end
    if (pop) void'(exp_q.pop_front());
    if (bus.cfg_enable && !bus.stall) begin
      pend = (m_drop != 0);
      need = ev.size() + (pend ? 1 : 0);
      if (free >= need) begin
        if (pend) exp_q.push_back(mk(1'b1, 5'b0, bus.trace_prv, AW'(m_drop), '0, TW'(m_ts)));
        foreach (ev[j]) exp_q.push_back(ev[j]);
        m_drop = 0;
      end else if (pend && free >= 1) begin
        exp_q.push_back(mk(1'b1, 5'b0, bus.trace_prv, AW'(m_drop), '0, TW'(m_ts)));
        m_drop = ev.size();
      end else begin
        m_drop = m_drop + ev.size();
        if (m_drop > (1 << CNTW) - 1) m_drop = (1 << CNTW) - 1;
      end
    end
    m_prv = bus.trace_prv;
    m_ts  = (m_ts + 1) % (1 << TW);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ts   = 0;
      m_drop = 0;
      m_prv  = 2'b11;
    end else begin
      model_step();
    end
  end

  // ---------------- scoreboard compare + pop logger ----------------
  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
    #1;
    if (rst_n) begin
      chk("cyc_out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk_rec("cyc_out_data", bus.out_data, exp_q[0]);
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bus.cfg_enable     = 1'b0;
    bus.cfg_event_mask = 5'b0;
    bus.stall          = 1'b0;
    bus.out_ready      = 1'b0;
    bus.trace_prv      = 2'b11;
    clr();
    tick(2);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk_rec("rst_data", bus.out_data, '0);
    rst_n = 1'b1;

    // Two channels, one cycle, two records in channel order with equal ts.
    bus.cfg_enable = 1'b1; bus.cfg_event_mask = 5'b00011; bus.out_ready = 1'b1;
    set_ch(0, 6'b000001, 64'h100, 64'h200);
    set_ch(1, 6'b000010, 64'h104, 64'h300);
    tick(); clr();
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_r0_type", f_ty(bus.out_data), 64'h01);
    chk("t1_r0_pc", f_pc(bus.out_data), 64'h100);
    chk("t1_r0_npc", f_npc(bus.out_data), 64'h200);
    chk("t1_r0_ts", f_ts(bus.out_data), 64'd0);
    tick();
    chk("t1_r1_type", f_ty(bus.out_data), 64'h02);
    chk("t1_r1_pc", f_pc(bus.out_data), 64'h104);
    chk("t1_r1_npc", f_npc(bus.out_data), 64'h300);
    chk("t1_r1_ts", f_ts(bus.out_data), 64'd0);
    tick();
    chk("t1_empty", 64'(bus.out_valid), 64'd0);

    // Privilege change 3->0 with a jal: prv record first, only once.
    bus.cfg_event_mask = 5'b11111; bus.trace_prv = 2'b00;
    set_ch(0, 6'b000001, 64'h400, 64'h404);
    tick(); clr();
    chk("t2_prv_type", f_ty(bus.out_data), 64'h10);
    chk("t2_prv_prv", f_prv(bus.out_data), 64'd0);
    chk("t2_prv_pc", f_pc(bus.out_data), 64'd0);
    chk("t2_prv_ts", f_ts(bus.out_data), 64'd3);
    tick();
    chk("t2_jal_type", f_ty(bus.out_data), 64'h01);
    chk("t2_jal_pc", f_pc(bus.out_data), 64'h400);
    tick();
    chk("t2_no_repeat", 64'(bus.out_valid), 64'd0);

    // Mask filtering: untaken branch ignored, type is raw & mask.
    bus.cfg_event_mask = 5'b01100;
    set_ch(0, 6'b000100, 64'h500, 64'h508);
    set_ch(1, 6'b101101, 64'h504, 64'h50c);
    tick(); clr();
    chk("t2b_type", f_ty(bus.out_data), 64'h0c);
    chk("t2b_pc", f_pc(bus.out_data), 64'h504);
    tick();
    chk("t2b_single", 64'(bus.out_valid), 64'd0);

    // Overflow: fill, drop 6, drain one -> P(6) alone with drop=2, later P(2).
    bus.cfg_event_mask = 5'b00011; bus.out_ready = 1'b0;
    got_q.delete();
    for (int c = 0; c < 7; c++) begin
      set_ch(0, 6'b000001, 64'h1000 + 64'(8 * c), 64'h0);
      set_ch(1, 6'b000001, 64'h1004 + 64'(8 * c), 64'h0);
      tick();
    end
    clr();
    chk("t3_full_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    set_ch(0, 6'b000001, 64'h1800, 64'h0);
    set_ch(1, 6'b000001, 64'h1804, 64'h0);
    tick(); clr();
    bus.out_ready = 1'b1;
    tick(12);
    chk("t3_pop_count", 64'(got_q.size()), 64'd10);
    if (got_q.size() == 10) begin
      chk("t3_first_pc", f_pc(got_q[0]), 64'h1000);
      chk("t3_p6_ovf", f_ovf(got_q[8]), 64'd1);
      chk("t3_p6_pc", f_pc(got_q[8]), 64'd6);
      chk("t3_p6_type", f_ty(got_q[8]), 64'd0);
      chk("t3_p2_ovf", f_ovf(got_q[9]), 64'd1);
      chk("t3_p2_pc", f_pc(got_q[9]), 64'd2);
    end
    set_ch(0, 6'b000001, 64'h2000, 64'h2004);
    tick(); clr(); tick();
    chk("t3_resume_count", 64'(got_q.size()), 64'd11);
    if (got_q.size() == 11) begin
      chk("t3_resume_ovf", f_ovf(got_q[10]), 64'd0);
      chk("t3_resume_pc", f_pc(got_q[10]), 64'h2000);
    end

    // Stall, then disable: nothing written, nothing counted as dropped.
    bus.stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_ch(0, 6'b000001, 64'h2100, 64'h0);
      set_ch(1, 6'b000010, 64'h2104, 64'h0);
      tick();
      chk("t4_stall_empty", 64'(bus.out_valid), 64'd0);
    end
    bus.stall = 1'b0; clr();
    set_ch(0, 6'b000001, 64'h3000, 64'h0);
    tick(); clr();
    chk("t4_stall_ovf", f_ovf(bus.out_data), 64'd0);
    chk("t4_stall_pc", f_pc(bus.out_data), 64'h3000);
    tick();
    bus.cfg_enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_ch(0, 6'b000001, 64'h2200, 64'h0);
      set_ch(1, 6'b000010, 64'h2204, 64'h0);
      tick();
      chk("t4_dis_empty", 64'(bus.out_valid), 64'd0);
    end
    bus.cfg_enable = 1'b1; clr();
    set_ch(0, 6'b000001, 64'h4000, 64'h0);
    tick(); clr();
    chk("t4_dis_ovf", f_ovf(bus.out_data), 64'd0);
    chk("t4_dis_pc", f_pc(bus.out_data), 64'h4000);
    tick();

    // Mid-operation reset with 5 queued records.
    bus.out_ready = 1'b0;
    set_ch(0, 6'b000001, 64'h4100, 64'h0); set_ch(1, 6'b000001, 64'h4104, 64'h0); tick();
    set_ch(0, 6'b000001, 64'h4108, 64'h0); set_ch(1, 6'b000001, 64'h410c, 64'h0); tick();
    clr();
    set_ch(0, 6'b000001, 64'h4110, 64'h0); tick();
    clr();
    chk("t5_pre_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    set_ch(0, 6'b000001, 64'h5000, 64'h0);
    tick(); clr();
    chk("t5_ts_restart", f_ts(bus.out_data), 64'd0);
    chk("t5_fresh_pc", f_pc(bus.out_data), 64'h5000);
    tick();
    chk("t5_no_stale", 64'(bus.out_valid), 64'd0);

    // Timestamp wrap at 4 bits: 15 then 1.
    tick(13);
    set_ch(0, 6'b000001, 64'h6000, 64'h0);
    tick(); clr();
    chk("t6_ts15", f_ts(bus.out_data), 64'd15);
    tick();
    set_ch(0, 6'b000001, 64'h6004, 64'h0);
    tick(); clr();
    chk("t6_ts1", f_ts(bus.out_data), 64'd1);
    chk("t6_pc", f_pc(bus.out_data), 64'h6004);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/osd_ctm_mc.md
# osd_ctm_mc

Multi-channel, parametrised core trace capture front-end for superscalar cores, next generation of the single-retire core trace module. Up to NUM_CH instructions can retire per cycle. Each cycle the block:
- filters the retires and privilege changes against a runtime event mask,
- timestamps the accepted events,
- writes them in order into an internal multi-write FIFO,
- reports lost events with an explicit in-band overflow record.

Its output is a valid/ready record stream that feeds the existing trace packetization stage.

## Interface
- ADDR_WIDTH, 64, width of pc/npc.
- NUM_CH, 2, retire channels per cycle (1..4); channel 0 is oldest in program order.
- TS_WIDTH, 32, timestamp width.
- DEPTH, 8, FIFO entries; power of two, ≥ NUM_CH+2.
- CNT_WIDTH, 16, drop counter width; ≤ ADDR_WIDTH.
- EW (derived, not settable): 8 + 2·ADDR_WIDTH + TS_WIDTH.

Ports:
- clk  in  1  sole clock; all state on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_enable  in  1  capture enable.
- cfg_event_mask  in  5  event-type enable bits, one per type bit (type bits defined under Operation).
- stall  in  1  downstream/debug stall; suppresses capture.
- trace_valid  in  NUM_CH  per-channel retire valid.
- trace_pc, trace_npc  in  NUM_CH·ADDR_WIDTH each  packed; channel i at [i·AW +: AW].
- trace_jal, trace_jalr, trace_branch, trace_br_taken, trace_trap, trace_xcpt  in  NUM_CH each  per-channel retire attributes.
- trace_prv  in  2  current privilege level, shared by all channels.
- out_data  out  EW  head record.
- out_valid  out  1  head record valid.
- out_ready  in  1  consumer accepts the head record.

## Operation
- Record layout, MSB→LSB: ovf(1), type(5), prv(2), pc(AW), npc(AW), ts(TS_WIDTH).
- Type bits:
  - 0: jal.
  - 1: jalr.
  - 2: branch taken, computed as trace_branch & trace_br_taken.
  - 3: trap or exception, computed as trace_trap | trace_xcpt.
  - 4: privilege change.
- Channel i qualifies when trace_valid[i] is set and (raw type & cfg_event_mask) ≠ 0.
  - Its recorded type field is the raw type ANDed with the mask.
  - ovf=0; prv=trace_prv.
- Privilege-change record:
  - Generated when prv_reg ≠ trace_prv and mask[4] is set.
  - type=5'b10000, pc=npc=0, prv=trace_prv.
  - Ordered before all channel records of the same cycle.
- prv_reg always tracks trace_prv every cycle, regardless of enable or stall.
- Timestamp:
  - Free-running counter; reset 0; +1 every cycle.
  - Wraps modulo 2^TS_WIDTH.
  - All records written in a cycle carry that cycle's counter value.
- Capture inhibit: when cfg_enable=0 or stall=1, nothing is written and nothing is counted as dropped. This does not apply to the FIFO read side.
- Per-cycle write set, with n = number of qualifying events (0..NUM_CH+1):
  - P is the overflow record: ovf=1, type=0, prv=trace_prv, pc = zero-extended drop_cnt, npc=0, current ts.
  - P is pending when drop_cnt ≠ 0.
  - Needed slots: n, plus 1 if P is pending.
  - Free slots are evaluated before this cycle's read.
- All-or-nothing, in order:
  - free ≥ needed: write P first (if pending), then the events in order; clear drop_cnt.
  - Otherwise, if P is pending and free ≥ 1: write P alone, and set drop_cnt = n.
  - Otherwise, with no write: drop_cnt += n, saturating at 2^CNT_WIDTH−1.
- Read side: out_data/out_valid present the FIFO head. A pop occurs on out_valid & out_ready.

## Timing
- Reset values: out_valid=0, out_data=0, FIFO empty, drop_cnt=0, timestamp=0, prv_reg=2'b11.
- Reset asserted mid-operation: all in-flight records are discarded immediately, asynchronously.
- Latency: an event qualifying in cycle t on an empty FIFO gives out_valid=1 from cycle t+1.
- Handshake: while out_valid=1 and out_ready=0, out_data stays stable and out_valid stays high.
- Free-slot rule: free counts entries before the same-cycle pop. A simultaneous pop does not create room for a write in that cycle.
- Full FIFO: out_valid stays 1; writes follow the drop rules above.
- Throughput: one record out per cycle; up to NUM_CH+2 records in per cycle.
- Pointer arithmetic: pointers are log2(DEPTH)+1 bits, wrap naturally. Full/empty come from the MSB compare.

## Structure
- Shared package osd_ctm_mc_pkg holds:
  - type-bit index constants: EV_JAL=0, EV_JALR=1, EV_BR=2, EV_TRAP=3, EV_PRV=4;
  - the record field-offset functions of ADDR_WIDTH/TS_WIDTH.
- One sub-module, osd_fifo_mwr: parametrised WIDTH/DEPTH/NWR FIFO.
  - In-order write of k ≤ NWR entries per cycle.
  - Exposes a free count.
  - Single-read valid/ready output.
- Event qualification, ordering compaction, drop counter and timestamp live in the top module.

## Test plan
- NUM_CH=2, mask=5'b00011, one cycle with ch0 jal (pc=0x100, npc=0x200) and ch1 jalr (pc=0x104, npc=0x300), out_ready=1 → two records at cycles t+1 and t+2 in channel order, types 00001 then 00010, equal ts.
- trace_prv changes 3→0 in the same cycle as a ch0 jal, mask=5'b11111 → prv record (type 10000, prv=0) precedes the jal record, and no further prv record appears next cycle.
- out_ready=0, FIFO filled to DEPTH, then 3 cycles of 2 qualifying events each → drop_cnt=6, no writes. Drain one entry → exactly one ovf record with pc=6 is written, then normal capture resumes.
- Qualifying events every cycle with stall=1, and separately with cfg_enable=0 → no records and drop_cnt stays 0.
- rst_n pulsed low for 1 cycle while 5 records are queued and out_ready=0 → out_valid=0 immediately; after release, timestamp restarts at 0 and no stale record emerges.
- TS_WIDTH=4, event at counter 15 and another event two cycles later → ts fields 15 and 1 (wrap).
